// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage.
//   fetch_state_t : fetch FSM states
//   fetch_entry_t : {instr, pc} payload held by the skid buffer and IF/ID
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W  = 64;
  localparam int unsigned FETCH_INSTR_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DROP = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_INSTR_W-1:0] instr;
    logic [FETCH_ADDR_W-1:0]  pc;
  } fetch_entry_t;

  // Pack an instruction word and its address into one entry.
  function automatic fetch_entry_t make_entry(input logic [FETCH_INSTR_W-1:0] instr,
                                              input logic [FETCH_ADDR_W-1:0]  pc);
    fetch_entry_t e;
    e.instr = instr;
    e.pc    = pc;
    return e;
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a fetched word that decode could not take.
//   clock, reset : clock and asynchronous active-low reset
//   load, din    : capture din, mark valid (load wins over clear)
//   clear        : mark empty
//   valid, dout  : held entry and its valid flag
module fetch_skid_buffer
  import fetch_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  fetch_entry_t din,
  output logic         valid,
  output fetch_entry_t dout
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues req/ack fetches at the PC, fills IF/ID,
// stalls the PC until a fetch completes, absorbs decode back-pressure in a
// one-entry skid and squashes in-flight fetches on a branch flush.
//   clock, reset            : clock and asynchronous active-low reset
//   pc, flush               : current PC and taken-branch strobe
//   id_stall                : decode cannot accept a new entry
//   fetch_stall             : stall to the PC (combinational)
//   imem_req/addr/ack/rdata : instruction memory handshake
//   if_id_valid/instr/pc    : IF/ID pipeline register
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = FETCH_ADDR_W,
  parameter int unsigned INSTR_W = FETCH_INSTR_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               flush,
  input  logic               id_stall,
  output logic               fetch_stall,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc
);

  fetch_state_t state, next_state;
  logic [ADDR_W-1:0] drop_addr;
  fetch_entry_t      if_id_q;
  fetch_entry_t      skid_dout;
  fetch_entry_t      mem_entry;
  logic              skid_valid;
  logic              accept;
  logic              busy_load, hold_load, skid_load, skid_clear, drop_load;

  assign accept    = !if_id_valid || !id_stall;
  assign mem_entry = make_entry(FETCH_INSTR_W'(imem_rdata), FETCH_ADDR_W'(pc));

  fetch_skid_buffer u_skid (
    .clock (clock),
    .reset (reset),
    .load  (skid_load),
    .clear (skid_clear),
    .din   (mem_entry),
    .valid (skid_valid),
    .dout  (skid_dout)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next state, memory request and PC stall. Stall is dropped whenever flush
  // is high because the PC lets stall override a branch.
  always_comb begin
    next_state  = state;
    fetch_stall = 1'b1;
    imem_req    = 1'b0;
    imem_addr   = pc;
    busy_load   = 1'b0;
    hold_load   = 1'b0;
    skid_load   = 1'b0;
    skid_clear  = 1'b0;
    drop_load   = 1'b0;
    case (state)
      IDLE: begin
        next_state  = BUSY;
        fetch_stall = !flush;
      end
      BUSY: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          fetch_stall = 1'b0;
          if (!flush) begin
            if (accept) begin
              busy_load = 1'b1;
            end else begin
              skid_load  = 1'b1;
              next_state = HOLD;
            end
          end
        end else if (flush) begin
          // Memory still owes a response for the old address; retire it in DROP.
          fetch_stall = 1'b0;
          drop_load   = 1'b1;
          next_state  = DROP;
        end
      end
      DROP: begin
        imem_req    = 1'b1;
        imem_addr   = drop_addr;
        fetch_stall = !flush;
        if (imem_ack) next_state = BUSY;
      end
      HOLD: begin
        if (flush) begin
          fetch_stall = 1'b0;
          skid_clear  = 1'b1;
          next_state  = BUSY;
        end else if (accept && skid_valid) begin
          hold_load  = 1'b1;
          skid_clear = 1'b1;
          next_state = BUSY;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Address of the abandoned request, held while its response drains.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)         drop_addr <= '0;
    else if (drop_load) drop_addr <= pc;
  end

  // IF/ID register: flush > load > drain when decode takes it > hold.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      if_id_valid <= 1'b0;
      if_id_q     <= '0;
    end else if (flush) begin
      if_id_valid <= 1'b0;
    end else if (busy_load || hold_load) begin
      if_id_valid <= 1'b1;
      if_id_q     <= busy_load ? mem_entry : skid_dout;
    end else if (!id_stall) begin
      if_id_valid <= 1'b0;
    end
  end

  assign if_id_instr = INSTR_W'(if_id_q.instr);
  assign if_id_pc    = ADDR_W'(if_id_q.pc);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; the bench plays both the PC and memory.
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic [63:0] pc;
  logic        flush;
  logic        id_stall;
  logic        fetch_stall;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [63:0] if_id_pc;

  int total = 0;
  int bad   = 0;

  fetch_unit #(.ADDR_W(64), .INSTR_W(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .pc          (pc),
    .flush       (flush),
    .id_stall    (id_stall),
    .fetch_stall (fetch_stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .if_id_valid (if_id_valid),
    .if_id_instr (if_id_instr),
    .if_id_pc    (if_id_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic v, input logic [63:0] p,
                          input logic [31:0] i);
    chk({tag, "_valid"}, 64'(if_id_valid), 64'(v));
    chk({tag, "_pc"},    if_id_pc, p);
    chk({tag, "_instr"}, 64'(if_id_instr), 64'(i));
  endtask

  initial begin
    reset = 1'b0; pc = 64'h0; flush = 1'b0; id_stall = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0;

    // Reset state
    tick(); tick();
    chk("rst_req",   64'(imem_req), 64'd0);
    chk("rst_stall", 64'(fetch_stall), 64'd1);
    chk_ifid("rst", 1'b0, 64'h0, 32'h0);

    // Reset release: IDLE for one cycle, then request at pc
    reset = 1'b1;
    #1;
    chk("idle_req",   64'(imem_req), 64'd0);
    chk("idle_stall", 64'(fetch_stall), 64'd1);
    tick();
    chk("busy_req",  64'(imem_req), 64'd1);
    chk("busy_addr", imem_addr, 64'h0);

    // Back-to-back zero-latency fetches at 0,4,8
    imem_ack = 1'b1; imem_rdata = 32'hA000_0000; pc = 64'h0;
    #1;
    chk("b2b0_stall", 64'(fetch_stall), 64'd0);
    tick();
    chk_ifid("b2b0", 1'b1, 64'h0, 32'hA000_0000);
    pc = 64'h4; imem_rdata = 32'hA000_0001;
    #1;
    chk("b2b1_addr",  imem_addr, 64'h4);
    chk("b2b1_stall", 64'(fetch_stall), 64'd0);
    tick();
    chk_ifid("b2b1", 1'b1, 64'h4, 32'hA000_0001);
    pc = 64'h8; imem_rdata = 32'hA000_0002;
    tick();
    chk_ifid("b2b2", 1'b1, 64'h8, 32'hA000_0002);

    // Three-cycle memory latency at 0x10
    imem_ack = 1'b0; pc = 64'h10;
    #1;
    chk("lat0_stall", 64'(fetch_stall), 64'd1);
    chk("lat0_addr",  imem_addr, 64'h10);
    tick();
    chk("lat1_stall", 64'(fetch_stall), 64'd1);
    chk("lat1_addr",  imem_addr, 64'h10);
    chk("lat1_valid", 64'(if_id_valid), 64'd0);
    tick();
    chk("lat2_stall", 64'(fetch_stall), 64'd1);
    chk("lat2_addr",  imem_addr, 64'h10);
    tick();
    imem_ack = 1'b1; imem_rdata = 32'hB010_B010;
    #1;
    chk("lat_ack_stall", 64'(fetch_stall), 64'd0);
    tick();
    chk_ifid("lat", 1'b1, 64'h10, 32'hB010_B010);

    // Back-pressure: ack while IF/ID full and decode stalled goes to HOLD
    id_stall = 1'b1; pc = 64'h20; imem_rdata = 32'hC020_C020;
    #1;
    chk("hold_ack_stall", 64'(fetch_stall), 64'd0);
    tick();
    imem_ack = 1'b0; pc = 64'h24;
    #1;
    chk("hold_req",   64'(imem_req), 64'd0);
    chk("hold_stall", 64'(fetch_stall), 64'd1);
    chk_ifid("hold_keep", 1'b1, 64'h10, 32'hB010_B010);
    tick();
    chk("hold2_req", 64'(imem_req), 64'd0);
    id_stall = 1'b0;
    #1;
    chk("hold_rel_stall", 64'(fetch_stall), 64'd1);
    tick();
    chk_ifid("skid_out", 1'b1, 64'h20, 32'hC020_C020);
    chk("after_hold_req",  64'(imem_req), 64'd1);
    chk("after_hold_addr", imem_addr, 64'h24);

    // Flush while BUSY with no ack: old request drains in DROP
    pc = 64'h30; flush = 1'b1;
    #1;
    chk("fl_stall", 64'(fetch_stall), 64'd0);
    chk("fl_addr",  imem_addr, 64'h30);
    tick();
    flush = 1'b0; pc = 64'h100;
    #1;
    chk("drop_valid", 64'(if_id_valid), 64'd0);
    chk("drop_req",   64'(imem_req), 64'd1);
    chk("drop_addr",  imem_addr, 64'h30);
    chk("drop_stall", 64'(fetch_stall), 64'd1);
    tick();
    chk("drop2_addr", imem_addr, 64'h30);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("drop_ack_stall", 64'(fetch_stall), 64'd1);
    tick();
    imem_ack = 1'b0;
    #1;
    chk("drop_discard", 64'(if_id_valid), 64'd0);
    chk("tgt_req",  64'(imem_req), 64'd1);
    chk("tgt_addr", imem_addr, 64'h100);

    // Flush coincident with ack at 0x40: data discarded, no DROP
    imem_ack = 1'b1; imem_rdata = 32'hD100_D100;
    tick();
    chk_ifid("tgt_load", 1'b1, 64'h100, 32'hD100_D100);
    pc = 64'h40; imem_rdata = 32'hD040_D040; flush = 1'b1;
    #1;
    chk("flack_stall", 64'(fetch_stall), 64'd0);
    tick();
    flush = 1'b0; imem_ack = 1'b0; pc = 64'h200;
    #1;
    chk_ifid("flack", 1'b0, 64'h100, 32'hD100_D100);
    chk("flack_req",  64'(imem_req), 64'd1);
    chk("flack_addr", imem_addr, 64'h200);

    // Reset asserted while in DROP
    imem_ack = 1'b1; imem_rdata = 32'hD200_D200;
    tick();
    chk_ifid("pre_drop", 1'b1, 64'h200, 32'hD200_D200);
    imem_ack = 1'b0; pc = 64'h204; flush = 1'b1;
    tick();
    flush = 1'b0; pc = 64'h300;
    #1;
    chk("drop3_addr", imem_addr, 64'h204);
    chk("drop3_req",  64'(imem_req), 64'd1);
    reset = 1'b0;
    #1;
    chk("rstdrop_req",   64'(imem_req), 64'd0);
    chk("rstdrop_stall", 64'(fetch_stall), 64'd1);
    chk_ifid("rstdrop", 1'b0, 64'h0, 32'h0);

    // Reset asserted while in HOLD
    tick();
    reset = 1'b1;
    tick();
    chk("rel2_req",  64'(imem_req), 64'd1);
    chk("rel2_addr", imem_addr, 64'h300);
    imem_ack = 1'b1; imem_rdata = 32'hE000_0000;
    tick();
    chk_ifid("pre_hold", 1'b1, 64'h300, 32'hE000_0000);
    id_stall = 1'b1; pc = 64'h304; imem_rdata = 32'hE000_0001;
    tick();
    imem_ack = 1'b0;
    #1;
    chk("hold3_req",   64'(imem_req), 64'd0);
    chk("hold3_stall", 64'(fetch_stall), 64'd1);
    reset = 1'b0;
    #1;
    chk("rsthold_req",   64'(imem_req), 64'd0);
    chk("rsthold_stall", 64'(fetch_stall), 64'd1);
    chk_ifid("rsthold", 1'b0, 64'h0, 32'h0);
    tick();
    chk("rsthold2_req", 64'(imem_req), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly downstream of programcounter.
- Takes the current PC and issues a request/acknowledge transaction to instruction memory.
- Captures the returned word into the IF/ID pipeline register and drives the PC's stall input, so the PC advances only after a fetch completes.
- Handles decode back-pressure with a one-entry skid buffer, and handles branch flushes, including squashing a fetch still in flight.

Parameters:
- ADDR_W, 64, PC/instruction address width.
- INSTR_W, 32, instruction word width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pc  in  ADDR_W  current PC from programcounter.
- flush  in  1  taken branch; same cycle the PC's branch input is high.
- id_stall  in  1  decode cannot accept a new IF/ID entry this cycle.
- fetch_stall  out  1  drives programcounter stall input.
- imem_req  out  1  memory request valid.
- imem_addr  out  ADDR_W  request address.
- imem_ack  in  1  one-cycle pulse; response data valid this cycle.
- imem_rdata  in  INSTR_W  instruction word, valid with imem_ack.
- if_id_valid  out  1  IF/ID entry valid.
- if_id_instr  out  INSTR_W  fetched instruction.
- if_id_pc  out  ADDR_W  address of if_id_instr.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; if_id_valid=0; if_id_instr=0; if_id_pc=0; skid empty. Outputs during reset: imem_req=0, fetch_stall=1.
- accept = !if_id_valid || !id_stall.
- States: IDLE, BUSY, DROP, HOLD.
- imem_req=1 only in BUSY or DROP.
- imem_addr = pc in BUSY; drop_addr in DROP; pc otherwise (don't-care).
- Every cycle BUSY is entered or retained after an ack begins a new transaction. Back-to-back fetches have no bubble: one instruction per cycle with zero-latency ack.
- IDLE: always goes to BUSY next cycle. fetch_stall=1, except fetch_stall=0 when flush.
- BUSY transitions (ack=imem_ack):
  - ack & !flush & accept: IF/ID <= {1, imem_rdata, pc}; stay BUSY; fetch_stall=0.
  - ack & !flush & !accept: skid <= {imem_rdata, pc}; go HOLD; fetch_stall=0.
  - ack & flush: discard data; stay BUSY; fetch_stall=0 (PC loads branch target).
  - !ack & flush: drop_addr <= pc (old address); go DROP; fetch_stall=0.
  - !ack & !flush: stay BUSY; fetch_stall=1.
- DROP: the request stays asserted at drop_addr until ack; the data is discarded; then go BUSY. fetch_stall=1, except 0 when flush (a new branch is allowed, stay DROP).
- HOLD:
  - imem_req=0; fetch_stall=1.
  - When accept: IF/ID <= {1, skid}; go BUSY.
  - flush: empty the skid, go BUSY, fetch_stall=0.
- IF/ID register update priority: flush (valid<=0) > load > (!id_stall: valid<=0) > hold.
- if_id_instr and if_id_pc stay unchanged when not loaded.
- fetch_stall is combinational from state, imem_ack, accept and flush. It must never be 1 while flush=1, because the PC gives stall priority over branch.
- Addresses are not checked for alignment or overflow; pc wraps at 2^ADDR_W in the PC.

Decomposition:
- Package fetch_pkg: state enum (IDLE, BUSY, DROP, HOLD), ADDR_W/INSTR_W defaults, and a packed {instr, pc} entry struct used by both the skid buffer and IF/ID.
- One sub-module, fetch_skid_buffer: a one-entry register with load/clear/valid and the same asynchronous active-low reset. The FSM and IF/ID register stay in fetch_unit.

Test Plan:
- Reset release, memory acks in the cycle after each req, id_stall=0, pc 0,4,8:
  - imem_req rises 1 cycle after reset deasserts.
  - IF/ID shows (0,I0), (4,I1), (8,I2) on consecutive cycles.
  - fetch_stall=0 on ack cycles.
- 3-cycle memory latency at pc=0x10:
  - fetch_stall=1 and imem_addr=0x10 held stable for 3 cycles.
  - IF/ID = (0x10, rdata) the cycle after ack.
- id_stall=1 with IF/ID full, then an ack at pc=0x20:
  - State goes to HOLD; skid holds (0x20, data); imem_req=0; fetch_stall=1.
  - Drop id_stall: IF/ID = (0x20, data) the next cycle; the next req uses the new pc.
- flush while BUSY with no ack, at pc=0x30, branch target 0x100:
  - fetch_stall=0 in the flush cycle; if_id_valid=0 next cycle.
  - imem_addr stays 0x30 until ack; that data is discarded (if_id_valid stays 0).
  - Next request is 0x100.
- flush coincident with ack at pc=0x40:
  - Data is not loaded; if_id_valid=0; the next request goes to the branch target with no DROP.
- Reset asserted in DROP and in HOLD:
  - Outputs return immediately to reset values; imem_req=0 without waiting for a clock edge.
